// File: rtl/pong_pkg.sv
// Shared Pong definitions: the mode codes seen by the animation stage, the
// controller state type and the default game constants.
package pong_pkg;

   localparam logic [1:0] MODE_PLAY  = 2'b00;
   localparam logic [1:0] MODE_PAUSE = 2'b01;
   localparam logic [1:0] MODE_GOAL  = 2'b10;
   localparam logic [1:0] MODE_WIN   = 2'b11;

   // State codes equal the mode codes, so the state register drives mode directly.
   typedef enum logic [1:0] {
      ST_PLAY  = MODE_PLAY,
      ST_PAUSE = MODE_PAUSE,
      ST_GOAL  = MODE_GOAL,
      ST_WIN   = MODE_WIN
   } state_t;

   localparam int DEFAULT_WIN_SCORE  = 5;
   localparam int DEFAULT_SCORE_W    = 4;
   localparam int DEFAULT_GOAL_TICKS = 26;
   localparam int DEFAULT_WIN_TICKS  = 26;

   // Timer width is clog2 of the longer hold, kept at least one bit for TICKS = 1.
   function automatic int timer_width(input int goal_ticks, input int win_ticks);
      int longest;
      int w;
      longest = (goal_ticks > win_ticks) ? goal_ticks : win_ticks;
      w = $clog2(longest);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/pong_game_ctrl_hold_timer.sv
// Loadable down-counter shared by the GOAL and WIN holds; done while the count is zero.
module hold_timer #(
   parameter int W = 5
) (
   input  logic         BALL_CLOCK,
   input  logic         RESET_N,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         done
);

   logic [W-1:0] count_reg;

   always_ff @(posedge BALL_CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign done = (count_reg == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-state controller: scores, pause toggling and timed GOAL/WIN holds
// that give the LED animation stage time to finish its sequences.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE  = DEFAULT_WIN_SCORE,
   parameter int SCORE_W    = DEFAULT_SCORE_W,
   parameter int GOAL_TICKS = DEFAULT_GOAL_TICKS,
   parameter int WIN_TICKS  = DEFAULT_WIN_TICKS
) (
   input  logic               BALL_CLOCK,
   input  logic               RESET_N,
   input  logic               pause_btn,
   input  logic               goal_left,
   input  logic               goal_right,
   output logic [1:0]         mode,
   output logic [SCORE_W-1:0] score_left,
   output logic [SCORE_W-1:0] score_right,
   output logic               ball_enable,
   output logic               winner
);

   localparam int CNT_W = timer_width(GOAL_TICKS, WIN_TICKS);
   localparam logic [CNT_W-1:0]   GOAL_LOAD = CNT_W'(GOAL_TICKS - 1);
   localparam logic [CNT_W-1:0]   WIN_LOAD  = CNT_W'(WIN_TICKS - 1);
   localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

   state_t             state_reg;
   logic [SCORE_W-1:0] score_left_reg;
   logic [SCORE_W-1:0] score_right_reg;
   logic               winner_reg;
   logic               ball_enable_reg;
   logic               pause_prev_reg;

   logic               pause_edge;
   logic               goal_single;
   logic [SCORE_W-1:0] left_inc;
   logic [SCORE_W-1:0] right_inc;
   logic               hits_win;
   logic               timer_load;
   logic [CNT_W-1:0]   timer_load_value;
   logic               timer_done;

   assign pause_edge  = pause_btn & ~pause_prev_reg;
   // Simultaneous goals are treated as a glitch, so only a lone pulse scores.
   assign goal_single = goal_left ^ goal_right;
   assign left_inc    = score_left_reg + 1'b1;
   assign right_inc   = score_right_reg + 1'b1;

   always_comb begin
      hits_win         = 1'b0;
      timer_load       = 1'b0;
      timer_load_value = GOAL_LOAD;
      if (goal_left) begin
         hits_win = (left_inc == WIN_VAL);
      end else begin
         hits_win = (right_inc == WIN_VAL);
      end
      if (state_reg == ST_PLAY && !pause_edge && goal_single) begin
         timer_load       = 1'b1;
         timer_load_value = hits_win ? WIN_LOAD : GOAL_LOAD;
      end
   end

   hold_timer #(
      .W(CNT_W)
   ) u_hold_timer (
      .BALL_CLOCK (BALL_CLOCK),
      .RESET_N    (RESET_N),
      .load       (timer_load),
      .load_value (timer_load_value),
      .done       (timer_done)
   );

   always_ff @(posedge BALL_CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg       <= ST_PLAY;
         score_left_reg  <= '0;
         score_right_reg <= '0;
         winner_reg      <= 1'b0;
         ball_enable_reg <= 1'b1;
         pause_prev_reg  <= 1'b0;
      end else begin
         pause_prev_reg <= pause_btn;
         case (state_reg)
            ST_PLAY: begin
               if (pause_edge) begin
                  state_reg       <= ST_PAUSE;
                  ball_enable_reg <= 1'b0;
               end else if (goal_single) begin
                  if (goal_left) begin
                     score_left_reg <= left_inc;
                  end else begin
                     score_right_reg <= right_inc;
                  end
                  ball_enable_reg <= 1'b0;
                  if (hits_win) begin
                     state_reg  <= ST_WIN;
                     winner_reg <= goal_right;
                  end else begin
                     state_reg <= ST_GOAL;
                  end
               end
            end
            ST_PAUSE: begin
               if (pause_edge) begin
                  state_reg       <= ST_PLAY;
                  ball_enable_reg <= 1'b1;
               end
            end
            ST_GOAL: begin
               if (timer_done) begin
                  state_reg       <= ST_PLAY;
                  ball_enable_reg <= 1'b1;
               end
            end
            ST_WIN: begin
               if (timer_done) begin
                  state_reg       <= ST_PLAY;
                  ball_enable_reg <= 1'b1;
                  score_left_reg  <= '0;
                  score_right_reg <= '0;
                  winner_reg      <= 1'b0;
               end
            end
            default: begin
               state_reg       <= ST_PLAY;
               ball_enable_reg <= 1'b1;
            end
         endcase
      end
   end

   assign mode        = state_reg;
   assign score_left  = score_left_reg;
   assign score_right = score_right_reg;
   assign winner      = winner_reg;
   assign ball_enable = ball_enable_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl against a cycle-level game model.
module tb_pong_game_ctrl;

   localparam int WIN_SCORE  = 5;
   localparam int SCORE_W    = 4;
   localparam int GOAL_TICKS = 26;
   localparam int WIN_TICKS  = 26;

   logic               BALL_CLOCK = 1'b0;
   logic               RESET_N    = 1'b0;
   logic               pause_btn  = 1'b0;
   logic               goal_left  = 1'b0;
   logic               goal_right = 1'b0;
   logic [1:0]         mode;
   logic [SCORE_W-1:0] score_left;
   logic [SCORE_W-1:0] score_right;
   logic               ball_enable;
   logic               winner;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: mode 0 play, 1 pause, 2 goal, 3 win; hold = cycles still to spend.
   int m_mode, m_sl, m_sr, m_win, m_hold, m_prev;

   pong_game_ctrl #(
      .WIN_SCORE  (WIN_SCORE),
      .SCORE_W    (SCORE_W),
      .GOAL_TICKS (GOAL_TICKS),
      .WIN_TICKS  (WIN_TICKS)
   ) dut (
      .BALL_CLOCK  (BALL_CLOCK),
      .RESET_N     (RESET_N),
      .pause_btn   (pause_btn),
      .goal_left   (goal_left),
      .goal_right  (goal_right),
      .mode        (mode),
      .score_left  (score_left),
      .score_right (score_right),
      .ball_enable (ball_enable),
      .winner      (winner)
   );

   initial forever #5 BALL_CLOCK = ~BALL_CLOCK;

   task automatic model_reset();
      m_mode = 0; m_sl = 0; m_sr = 0; m_win = 0; m_hold = 0; m_prev = 0;
   endtask

   task automatic model_step();
      bit pe;
      pe = pause_btn && !m_prev;
      m_prev = pause_btn;
      case (m_mode)
         0: begin
            if (pe) m_mode = 1;
            else if (goal_left != goal_right) begin
               if (goal_left) m_sl++; else m_sr++;
               if ((goal_left ? m_sl : m_sr) == WIN_SCORE) begin
                  m_mode = 3; m_hold = WIN_TICKS; m_win = goal_right;
               end else begin
                  m_mode = 2; m_hold = GOAL_TICKS;
               end
            end
         end
         1: if (pe) m_mode = 0;
         default: begin
            m_hold--;
            if (m_hold == 0) begin
               if (m_mode == 3) begin m_sl = 0; m_sr = 0; m_win = 0; end
               m_mode = 0;
            end
         end
      endcase
   endtask

   function automatic logic [11:0] exp_vec();
      return {2'(m_mode), 4'(m_sl), 4'(m_sr), (m_mode == 0), 1'(m_win)};
   endfunction

   function automatic logic [11:0] obs_vec();
      return {mode, score_left, score_right, ball_enable, winner};
   endfunction

   task automatic tick();
      @(posedge BALL_CLOCK);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge BALL_CLOCK);
      #1;
      n_checks++;
      if (obs_vec() !== 12'b00_0000_0000_1_0) begin
         n_fail++;
         $display("FAIL reset: got %h expected %h", obs_vec(), 12'b00_0000_0000_1_0);
      end
      RESET_N = 1'b1;
      model_reset();
      $display("reset released: mode=%b scores=%0d/%0d", mode, score_left, score_right);
   endtask

   task automatic test_goal();
      int goal_cycles;
      goal_cycles = 0;
      repeat (9) tick();
      goal_left = 1'b1;
      tick();
      goal_left = 1'b0;
      n_checks++;
      if (mode !== 2'b10 || score_left !== 4'd1) begin
         n_fail++;
         $display("FAIL goal_entry: mode=%b score_left=%0d expected mode=10 score_left=1", mode, score_left);
      end
      if (mode == 2'b10 && !ball_enable) goal_cycles++;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (mode == 2'b10 && !ball_enable) goal_cycles++;
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL goal_hold cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
      n_checks++;
      if (goal_cycles !== GOAL_TICKS) begin
         n_fail++;
         $display("FAIL goal_length: got %0d cycles expected %0d", goal_cycles, GOAL_TICKS);
      end
      $display("goal: %0d cycles in GOAL, mode now %b", goal_cycles, mode);
   endtask

   task automatic test_win();
      int win_cycles;
      win_cycles = 0;
      for (int g = 0; g < WIN_SCORE; g++) begin
         goal_right = 1'b1;
         tick();
         goal_right = 1'b0;
         if (g == WIN_SCORE - 1) begin
            n_checks++;
            if (mode !== 2'b11 || winner !== 1'b1 || score_right !== 4'(WIN_SCORE)) begin
               n_fail++;
               $display("FAIL win_entry: mode=%b winner=%b score_right=%0d expected 11/1/%0d",
                        mode, winner, score_right, WIN_SCORE);
            end
         end
         if (mode == 2'b11) win_cycles++;
         for (int i = 0; i < 27; i++) begin
            tick();
            if (mode == 2'b11) win_cycles++;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
               n_fail++;
               $display("FAIL win_seq goal %0d cyc %0d: got %h expected %h", g, i, obs_vec(), exp_vec());
            end
         end
      end
      n_checks++;
      if (win_cycles !== WIN_TICKS || obs_vec() !== 12'b00_0000_0000_1_0) begin
         n_fail++;
         $display("FAIL win_exit: win cycles %0d state %h expected %0d and %h",
                  win_cycles, obs_vec(), WIN_TICKS, 12'b00_0000_0000_1_0);
      end
      $display("win: %0d cycles in WIN, scores cleared to %0d/%0d", win_cycles, score_left, score_right);
   endtask

   task automatic test_pause();
      logic [SCORE_W-1:0] sl_before;
      sl_before = score_left;
      pause_btn = 1'b1;
      tick();
      n_checks++;
      if (mode !== 2'b01 || ball_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL pause_enter: mode=%b ball_enable=%b expected 01/0", mode, ball_enable);
      end
      for (int i = 0; i < 10; i++) begin
         goal_left = (i == 3);
         tick();
         n_checks++;
         if (obs_vec() !== exp_vec() || mode !== 2'b01 || score_left !== sl_before) begin
            n_fail++;
            $display("FAIL pause_hold cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
      goal_left = 1'b0;
      pause_btn = 1'b0;
      repeat (2) tick();
      pause_btn = 1'b1;
      tick();
      n_checks++;
      if (mode !== 2'b00 || ball_enable !== 1'b1) begin
         n_fail++;
         $display("FAIL pause_exit: mode=%b ball_enable=%b expected 00/1", mode, ball_enable);
      end
      pause_btn = 1'b0;
      tick();
      $display("pause: toggled in and out, mode=%b score_left=%0d", mode, score_left);
   endtask

   task automatic test_simultaneous();
      goal_left = 1'b1; goal_right = 1'b1;
      tick();
      goal_left = 1'b0; goal_right = 1'b0;
      n_checks++;
      if (obs_vec() !== exp_vec() || mode !== 2'b00) begin
         n_fail++;
         $display("FAIL both_goals: got %h expected %h", obs_vec(), exp_vec());
      end
      goal_left = 1'b1; pause_btn = 1'b1;
      tick();
      goal_left = 1'b0;
      n_checks++;
      if (obs_vec() !== exp_vec() || mode !== 2'b01) begin
         n_fail++;
         $display("FAIL pause_beats_goal: got %h expected %h", obs_vec(), exp_vec());
      end
      pause_btn = 1'b0;
      tick();
      pause_btn = 1'b1;
      tick();
      pause_btn = 1'b0;
      tick();
      $display("simultaneous: mode=%b scores=%0d/%0d", mode, score_left, score_right);
   endtask

   task automatic test_async_reset();
      int goal_cycles;
      goal_cycles = 0;
      goal_left = 1'b1;
      tick();
      goal_left = 1'b0;
      repeat (13) tick();
      RESET_N = 1'b0;
      #2;
      n_checks++;
      if (obs_vec() !== 12'b00_0000_0000_1_0) begin
         n_fail++;
         $display("FAIL async_reset: got %h expected %h", obs_vec(), 12'b00_0000_0000_1_0);
      end
      #1;
      RESET_N = 1'b1;
      model_reset();
      tick();
      goal_left = 1'b1;
      tick();
      goal_left = 1'b0;
      if (mode == 2'b10) goal_cycles++;
      for (int i = 0; i < 28; i++) begin
         tick();
         if (mode == 2'b10) goal_cycles++;
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL post_reset cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
      n_checks++;
      if (goal_cycles !== GOAL_TICKS) begin
         n_fail++;
         $display("FAIL post_reset_length: got %0d expected %0d", goal_cycles, GOAL_TICKS);
      end
      $display("async reset: aborted GOAL, next GOAL lasted %0d cycles", goal_cycles);
   endtask

   task automatic test_hold_ignore();
      for (int phase = 0; phase < 2; phase++) begin
         int hold_cycles;
         logic [1:0] hold_mode;
         hold_mode = (phase == 0) ? 2'b10 : 2'b11;
         hold_cycles = 0;
         // Bring left one goal short of a win for the WIN phase.
         while (phase == 1 && m_sl < WIN_SCORE - 1) begin
            goal_left = 1'b1;
            tick();
            goal_left = 1'b0;
            repeat (GOAL_TICKS + 1) tick();
         end
         goal_left = 1'b1;
         tick();
         if (mode == hold_mode) hold_cycles++;
         for (int i = 0; i < 30; i++) begin
            if (i < 25) begin
               pause_btn  = 1'($urandom_range(0, 1));
               goal_left  = 1'($urandom_range(0, 1));
               goal_right = 1'($urandom_range(0, 1));
            end else begin
               pause_btn = 1'b0; goal_left = 1'b0; goal_right = 1'b0;
            end
            tick();
            if (mode == hold_mode) hold_cycles++;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
               n_fail++;
               $display("FAIL hold_noise ph %0d cyc %0d: got %h expected %h", phase, i, obs_vec(), exp_vec());
            end
         end
         n_checks++;
         if (hold_cycles !== ((phase == 0) ? GOAL_TICKS : WIN_TICKS)) begin
            n_fail++;
            $display("FAIL hold_noise_length ph %0d: got %0d expected %0d", phase, hold_cycles,
                     (phase == 0) ? GOAL_TICKS : WIN_TICKS);
         end
         $display("hold ignore phase %0d: %0d cycles in mode %b", phase, hold_cycles, hold_mode);
      end
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int i = 0; i < 1500; i++) begin
         goal_left  = ($urandom_range(0, 7) == 0);
         goal_right = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 9) == 0) pause_btn = ~pause_btn;
         tick();
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++; errs++;
            if (errs < 10)
               $display("FAIL random cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
      goal_left = 1'b0; goal_right = 1'b0; pause_btn = 1'b0;
      $display("random: 1500 cycles, %0d discrepancies", errs);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_goal();
      test_win();
      test_pause();
      test_simultaneous();
      test_async_reset();
      test_hold_ignore();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-state controller for Pong, sitting directly upstream of the LED animation stage. It receives goal pulses from the ball logic and the pause button. It keeps both scores and drives the 2-bit mode code: 00 play, 01 pause, 10 goal, 11 win. Goal and win modes are held for a fixed number of BALL_CLOCK ticks so the animation stage can finish its sequence before play resumes.

Parameters:
WIN_SCORE, 5, score that ends a match; must be between 1 and 2^SCORE_W-1.
SCORE_W, 4, width of each score counter.
GOAL_TICKS, 26, BALL_CLOCK cycles spent in goal mode.
WIN_TICKS, 26, BALL_CLOCK cycles spent in win mode.

Ports:
BALL_CLOCK  input  1  game tick clock; all logic is on its rising edge.
RESET_N  input  1  asynchronous, active-low reset.
pause_btn  input  1  pause button level, already debounced and synchronised to BALL_CLOCK.
goal_left  input  1  one-cycle pulse: left player scored.
goal_right  input  1  one-cycle pulse: right player scored.
mode  output  2  00 play, 01 pause, 10 goal, 11 win; registered.
score_left  output  SCORE_W  left score; registered.
score_right  output  SCORE_W  right score; registered.
ball_enable  output  1  1 only in PLAY; ball logic freezes when 0.
winner  output  1  0 = left, 1 = right; valid only while mode = 11.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - state PLAY; mode 00; both scores 0; winner 0; ball_enable 1.
  - tick counter 0; pause_btn history register 0.
- pause edge: pause_btn high with previous sample low. The history register updates every cycle in every state.
- FSM states, with mode encoding: PLAY (00), PAUSE (01), GOAL (10), WIN (11).
- All outputs are registered and reflect the new state one cycle after the triggering input edge.
- PLAY:
  - pause edge → PAUSE. A pause edge beats a goal pulse in the same cycle; the goal is dropped.
  - Exactly one goal pulse → increment that player's score.
    - If the new score equals WIN_SCORE → WIN, winner set to the scorer.
    - Otherwise → GOAL.
    - In both cases the counter loads (TICKS−1).
  - goal_left and goal_right in the same cycle → treated as a glitch: no score change, stay in PLAY.
- PAUSE:
  - pause edge → PLAY.
  - Goal pulses are ignored; scores are frozen.
- GOAL:
  - Counter decrements each cycle; when it is 0 → PLAY.
  - The state lasts exactly GOAL_TICKS cycles with mode = 10.
  - Pause edges and goal pulses are ignored.
- WIN:
  - Same countdown with WIN_TICKS.
  - Exit (counter 0) → PLAY, with both scores cleared to 0 and winner cleared to 0, all in the same edge.
  - Pause edges and goal pulses are ignored.
- Scores never exceed WIN_SCORE; there is no wrap-around.
- Counter width is clog2(max(GOAL_TICKS, WIN_TICKS)).
- TICKS = 1 is legal: the block spends a single cycle in GOAL or WIN.
- Reset mid-GOAL or mid-WIN aborts immediately to the reset values.
- pause_btn held high gives a single toggle only.
- A button held through GOAL, then released and pressed again in PLAY, pauses normally.

Decomposition:
- Shared package pong_pkg holds:
  - mode encoding constants MODE_PLAY = 2'b00, MODE_PAUSE = 2'b01, MODE_GOAL = 2'b10, MODE_WIN = 2'b11;
  - the state typedef;
  - default WIN_SCORE and TICKS constants.
- The animation stage imports the same mode constants.
- Sub-module hold_timer: loadable down-counter with load, load_value and done (count = 0). It is instantiated once and shared by GOAL and WIN.

Test Plan:
1. Reset release, then goal_left pulse at cycle 10:
   - score_left = 1 and mode = 10 from cycle 11 for 26 cycles;
   - mode = 00 at cycle 37; ball_enable low throughout GOAL.
2. Five goal_right pulses, each issued in PLAY:
   - after the 5th, mode = 11, winner = 1, score_right = 5 for 26 cycles;
   - then mode = 00 with both scores and winner = 0.
3. Pause handling:
   - pause_btn rises in PLAY → mode = 01; goal_left pulse while paused → score unchanged;
   - pause_btn held 10 cycles → no further toggle;
   - release, then rise again → mode = 00.
4. goal_left and goal_right in the same cycle → no score change, mode stays 00.
   - goal_left together with a pause edge → mode = 01, score_left unchanged.
5. RESET_N asserted mid-GOAL (counter at 12) → outputs take reset values immediately, without waiting for a clock edge.
   - After release, a goal_left pulse → mode = 10 for the full 26 cycles.
6. Pause edge and goal pulses during GOAL and during WIN → ignored.
   - Timing is unchanged: 26 cycles in each state.
